// File: rtl/seg_digit_mux.sv
// Eight-digit hex register file feeding a registered seven-segment driver,
// aligned one cycle behind the scanner. Optional blink feature: SEG_BLINK_EN.
module seg_digit_mux #(
  parameter int NDIG    = 8,
  parameter bit SEG_INV = 1'b0
`ifdef SEG_BLINK_EN
  ,
  parameter int BLINK_DIV = 24
`endif
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            WR_EN,
  input  logic [2:0]      WR_ADDR,
  input  logic [3:0]      WR_DATA,
  input  logic            WR_DP,
  input  logic            LZB,
  input  logic [2:0]      SEL,
  input  logic [NDIG-1:0] DIG_N,
`ifdef SEG_BLINK_EN
  input  logic [NDIG-1:0] BLINK_MASK,
`endif
  output logic [6:0]      SEG,
  output logic            DP,
  output logic [NDIG-1:0] DIG_OUT
);

  logic [3:0]      mem_q [NDIG];
  logic [NDIG-1:0] dp_q;
  logic [6:0]      seg_q, seg_d;
  logic            dpo_q, dpo_d;
  logic [NDIG-1:0] dig_q, dig_d;
  logic [NDIG-1:0] blank;
  logic [NDIG-1:0] dig_on;
  logic            scan_ok;
  logic            force_off;

  function automatic logic [6:0] hex_dec(input logic [3:0] v);
    case (v)
      4'h0: hex_dec = 7'h3F;
      4'h1: hex_dec = 7'h06;
      4'h2: hex_dec = 7'h5B;
      4'h3: hex_dec = 7'h4F;
      4'h4: hex_dec = 7'h66;
      4'h5: hex_dec = 7'h6D;
      4'h6: hex_dec = 7'h7D;
      4'h7: hex_dec = 7'h07;
      4'h8: hex_dec = 7'h7F;
      4'h9: hex_dec = 7'h6F;
      4'hA: hex_dec = 7'h77;
      4'hB: hex_dec = 7'h7C;
      4'hC: hex_dec = 7'h39;
      4'hD: hex_dec = 7'h5E;
      4'hE: hex_dec = 7'h79;
      default: hex_dec = 7'h71;
    endcase
  endfunction

  // A digit is a leading zero when it and everything left of it is zero and
  // no decimal point sits strictly to its left. Digit 0 always shows.
  always_comb begin
    blank = '0;
    blank[NDIG-1] = (mem_q[NDIG-1] == 4'h0);
    for (int i = NDIG - 2; i >= 1; i--) begin
      blank[i] = (mem_q[i] == 4'h0) && blank[i+1] && !dp_q[i+1];
    end
  end

  assign dig_on  = ~DIG_N;
  assign scan_ok = (dig_on != '0) && ((dig_on & (dig_on - NDIG'(1))) == '0);

`ifdef SEG_BLINK_EN
  logic [BLINK_DIV-1:0] blink_cnt_q;

  always_ff @(posedge CLK) begin
    if (RST) blink_cnt_q <= '0;
    else     blink_cnt_q <= blink_cnt_q + BLINK_DIV'(1);
  end

  assign force_off = !scan_ok || (blink_cnt_q[BLINK_DIV-1] && BLINK_MASK[SEL]);
`else
  assign force_off = !scan_ok;
`endif

  always_comb begin
    seg_d = hex_dec(mem_q[SEL]);
    dpo_d = dp_q[SEL];
    dig_d = scan_ok ? DIG_N : '1;
    if (LZB && blank[SEL]) seg_d = 7'h00;
    if (force_off) begin
      seg_d = 7'h00;
      dpo_d = 1'b0;
    end
    if (SEG_INV) begin
      seg_d = ~seg_d;
      dpo_d = ~dpo_d;
    end
  end

  // Outputs read the pre-write contents, so a same-cycle write to the
  // selected digit shows up on its next selection.
  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < NDIG; i++) mem_q[i] <= 4'h0;
      dp_q  <= '0;
      seg_q <= {7{SEG_INV}};
      dpo_q <= SEG_INV;
      dig_q <= '1;
    end else begin
      if (WR_EN) begin
        mem_q[WR_ADDR] <= WR_DATA;
        dp_q[WR_ADDR]  <= WR_DP;
      end
      seg_q <= seg_d;
      dpo_q <= dpo_d;
      dig_q <= dig_d;
    end
  end

  assign SEG     = seg_q;
  assign DP      = dpo_q;
  assign DIG_OUT = dig_q;

endmodule

// File: tb/tb_seg_digit_mux.sv
// Directed-vector bench for seg_digit_mux (default build, SEG_INV = 0).
module tb_seg_digit_mux;

  logic       CLK = 1'b0;
  logic       RST, WR_EN, WR_DP, LZB;
  logic [2:0] WR_ADDR, SEL;
  logic [3:0] WR_DATA;
  logic [7:0] DIG_N;
  logic [6:0] SEG;
  logic       DP;
  logic [7:0] DIG_OUT;
`ifdef SEG_BLINK_EN
  logic [7:0] BLINK_MASK = 8'h00;
`endif

  int vectors = 0;
  int miscompares = 0;

  always #5 CLK = ~CLK;

  seg_digit_mux dut (
    .CLK(CLK), .RST(RST), .WR_EN(WR_EN), .WR_ADDR(WR_ADDR), .WR_DATA(WR_DATA),
    .WR_DP(WR_DP), .LZB(LZB), .SEL(SEL), .DIG_N(DIG_N),
`ifdef SEG_BLINK_EN
    .BLINK_MASK(BLINK_MASK),
`endif
    .SEG(SEG), .DP(DP), .DIG_OUT(DIG_OUT)
  );

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%02h expected=%02h", tag, got, exp);
    end
  endtask

  task automatic wr(input logic [2:0] a, input logic [3:0] d, input logic p);
    WR_EN = 1'b1; WR_ADDR = a; WR_DATA = d; WR_DP = p;
    tick();
    WR_EN = 1'b0;
  endtask

  task automatic show(input logic [2:0] s, input string tag,
                      input logic [6:0] exp_seg, input logic exp_dp);
    logic [7:0] dn;
    dn = ~(8'h01 << s);
    SEL = s; DIG_N = dn;
    tick();
    check({tag, "_seg"}, {1'b0, SEG}, {1'b0, exp_seg});
    check({tag, "_dp"}, {7'b0, DP}, {7'b0, exp_dp});
    check({tag, "_dig"}, DIG_OUT, dn);
  endtask

  logic [6:0] scan_exp [8];

  initial begin
    scan_exp[0] = 7'h7F; scan_exp[1] = 7'h07; scan_exp[2] = 7'h7D; scan_exp[3] = 7'h6D;
    scan_exp[4] = 7'h66; scan_exp[5] = 7'h4F; scan_exp[6] = 7'h5B; scan_exp[7] = 7'h06;

    RST = 1'b1; WR_EN = 1'b0; WR_ADDR = 3'd0; WR_DATA = 4'h0; WR_DP = 1'b0;
    LZB = 1'b0; SEL = 3'd0; DIG_N = 8'hFE;
    tick(); tick();
    check("rst_seg", {1'b0, SEG}, 8'h00);
    check("rst_dp", {7'b0, DP}, 8'h00);
    check("rst_dig", DIG_OUT, 8'hFF);
    RST = 1'b0;
    show(3'd0, "post_rst", 7'h3F, 1'b0);

    // Load 8..1 into digits 0..7 while the scanner is idle.
    DIG_N = 8'hFF;
    for (int i = 0; i < 8; i++) wr(3'(i), 4'(8 - i), 1'b0);
    check("idle_seg", {1'b0, SEG}, 8'h00);
    check("idle_dig", DIG_OUT, 8'hFF);
    for (int i = 0; i < 8; i++) show(3'(i), $sformatf("scan%0d", i), scan_exp[i], 1'b0);

    wr(3'd2, 4'h6, 1'b1);
    show(3'd2, "dp2", 7'h7D, 1'b1);

    // Collision: write to the digit being read this cycle.
    wr(3'd3, 4'h1, 1'b0);
    WR_EN = 1'b1; WR_ADDR = 3'd3; WR_DATA = 4'hA; WR_DP = 1'b0;
    show(3'd3, "coll_old", 7'h06, 1'b0);
    WR_EN = 1'b0;
    show(3'd3, "coll_new", 7'h77, 1'b0);

    // Leading-zero blanking with contents 0000_0305.
    DIG_N = 8'hFF;
    for (int i = 0; i < 8; i++) wr(3'(i), 4'h0, 1'b0);
    wr(3'd0, 4'h5, 1'b0);
    wr(3'd2, 4'h3, 1'b0);
    LZB = 1'b1;
    show(3'd7, "lzb7", 7'h00, 1'b0);
    show(3'd5, "lzb5", 7'h00, 1'b0);
    show(3'd3, "lzb3", 7'h00, 1'b0);
    show(3'd2, "lzb2", 7'h4F, 1'b0);
    show(3'd1, "lzb1", 7'h3F, 1'b0);
    show(3'd0, "lzb0", 7'h6D, 1'b0);

    DIG_N = 8'hFF;
    wr(3'd0, 4'h0, 1'b0);
    wr(3'd2, 4'h0, 1'b0);
    show(3'd0, "zero0", 7'h3F, 1'b0);
    show(3'd1, "zero1", 7'h00, 1'b0);
    show(3'd5, "zero5", 7'h00, 1'b0);

    DIG_N = 8'hFF;
    wr(3'd5, 4'h0, 1'b1);
    show(3'd4, "dp5_d4", 7'h3F, 1'b0);
    show(3'd5, "dp5_d5", 7'h00, 1'b1);
    show(3'd3, "dp5_d3", 7'h3F, 1'b0);
    show(3'd6, "dp5_d6", 7'h00, 1'b0);
    LZB = 1'b0;
    show(3'd7, "nolzb7", 7'h3F, 1'b0);

    // Malformed scan enables force everything off.
    DIG_N = 8'hFF;
    wr(3'd0, 4'h8, 1'b1);
    SEL = 3'd0; DIG_N = 8'hFC;
    tick();
    check("inv2_seg", {1'b0, SEG}, 8'h00);
    check("inv2_dp", {7'b0, DP}, 8'h00);
    check("inv2_dig", DIG_OUT, 8'hFF);
    show(3'd0, "valid0", 7'h7F, 1'b1);
    DIG_N = 8'hFF;
    tick();
    check("inv0_seg", {1'b0, SEG}, 8'h00);
    check("inv0_dp", {7'b0, DP}, 8'h00);
    check("inv0_dig", DIG_OUT, 8'hFF);

    // Reset beats a simultaneous write.
    SEL = 3'd0; DIG_N = 8'hFE;
    RST = 1'b1; WR_EN = 1'b1; WR_ADDR = 3'd0; WR_DATA = 4'h9; WR_DP = 1'b1;
    tick();
    check("mid_rst_seg", {1'b0, SEG}, 8'h00);
    check("mid_rst_dig", DIG_OUT, 8'hFF);
    RST = 1'b0; WR_EN = 1'b0;
    show(3'd0, "after_rst0", 7'h3F, 1'b0);
    show(3'd5, "after_rst5", 7'h3F, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
